// File: rtl/led_pattern_sched_pkg.sv
// Shared encodings for the LED pattern scheduler: command layout, modes and
// per-channel state codes.
package led_sched_pkg;

   localparam int NUM_LEDS = 4;

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ON    = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;
   localparam logic [1:0] MODE_PULSE = 2'b11;

   localparam int CMD_W        = 11;
   localparam int CMD_IDX_LSB  = 9;
   localparam int CMD_IDX_W    = 2;
   localparam int CMD_MODE_LSB = 7;
   localparam int CMD_MODE_W   = 2;
   localparam int CMD_CNT_LSB  = 3;
   localparam int CMD_CNT_W    = 4;
   localparam int CMD_H_LSB    = 0;
   localparam int CMD_H_W      = 3;

   typedef logic [2:0] state_t;

   localparam state_t ST_OFF       = 3'd0;
   localparam state_t ST_ON        = 3'd1;
   localparam state_t ST_BLINK_ON  = 3'd2;
   localparam state_t ST_BLINK_OFF = 3'd3;
   localparam state_t ST_PULSE_ON  = 3'd4;
   localparam state_t ST_PULSE_OFF = 3'd5;

endpackage

// File: rtl/led_pattern_sched_channel.sv
// One LED channel: runs OFF/ON/BLINK/PULSE patterns, phases timed in prescaler ticks.
//   state        | meaning
//   ST_OFF       | LED dark, idle
//   ST_ON        | LED lit, idle
//   ST_BLINK_ON  | blink, lit phase
//   ST_BLINK_OFF | blink, dark phase
//   ST_PULSE_ON  | pulse train, lit phase
//   ST_PULSE_OFF | pulse train, dark phase; last one ends in ST_OFF with done
module led_channel
   import led_sched_pkg::*;
(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 tick,
   input  logic                 cmd_we,
   input  logic [CMD_MODE_W-1:0] cmd_mode,
   input  logic [CMD_CNT_W-1:0]  cmd_cnt,
   input  logic [CMD_H_W-1:0]    cmd_h,
   output logic                 led_n,
   output logic                 busy,
   output logic                 done
);

   state_t               state_q, state_d;
   logic [7:0]           phase_q, phase_d;
   logic [4:0]           left_q, left_d;
   logic [CMD_H_W-1:0]   h_q, h_d;
   logic                 done_q, done_d;
   logic [7:0]           phase_last;
   logic                 running;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      left_d     = left_q;
      h_d        = h_q;
      done_d     = 1'b0;
      phase_last = (8'd1 << h_q) - 8'd1;
      running    = (state_q == ST_BLINK_ON) || (state_q == ST_BLINK_OFF) ||
                   (state_q == ST_PULSE_ON) || (state_q == ST_PULSE_OFF);

      // A new command always wins over a phase end or completion in the same cycle.
      if (cmd_we) begin
         h_d     = cmd_h;
         phase_d = 8'd0;
         left_d  = (cmd_cnt == '0) ? 5'd16 : {1'b0, cmd_cnt};
         case (cmd_mode)
            MODE_OFF:   state_d = ST_OFF;
            MODE_ON:    state_d = ST_ON;
            MODE_BLINK: state_d = ST_BLINK_ON;
            default:    state_d = ST_PULSE_ON;
         endcase
      end else if (running && tick) begin
         if (phase_q == phase_last) begin
            phase_d = 8'd0;
            case (state_q)
               ST_BLINK_ON:  state_d = ST_BLINK_OFF;
               ST_BLINK_OFF: state_d = ST_BLINK_ON;
               ST_PULSE_ON:  state_d = ST_PULSE_OFF;
               ST_PULSE_OFF: begin
                  if (left_q == 5'd1) begin
                     state_d = ST_OFF;
                     done_d  = 1'b1;
                  end else begin
                     left_d  = left_q - 5'd1;
                     state_d = ST_PULSE_ON;
                  end
               end
               default:      state_d = ST_OFF;
            endcase
         end else begin
            phase_d = phase_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_OFF;
         phase_q <= 8'd0;
         left_q  <= 5'd0;
         h_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         left_q  <= left_d;
         h_q     <= h_d;
         done_q  <= done_d;
      end
   end

   assign led_n = !((state_q == ST_ON) || (state_q == ST_BLINK_ON) || (state_q == ST_PULSE_ON));
   assign busy  = (state_q == ST_BLINK_ON) || (state_q == ST_BLINK_OFF) ||
                  (state_q == ST_PULSE_ON) || (state_q == ST_PULSE_OFF);
   assign done  = done_q;

endmodule

// File: rtl/led_pattern_sched.sv
// LED pattern scheduler: tick prescaler, two-requester round-robin command
// arbiter and decode feeding one led_channel per LED.
module led_pattern_sched
   import led_sched_pkg::CMD_W, led_sched_pkg::CMD_IDX_LSB, led_sched_pkg::CMD_IDX_W,
          led_sched_pkg::CMD_MODE_LSB, led_sched_pkg::CMD_MODE_W,
          led_sched_pkg::CMD_CNT_LSB, led_sched_pkg::CMD_CNT_W,
          led_sched_pkg::CMD_H_LSB, led_sched_pkg::CMD_H_W;
#(
   parameter int TICK_DIV = 50000,
   parameter int NUM_LEDS = led_sched_pkg::NUM_LEDS
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                r0_valid,
   input  logic                r1_valid,
   output logic                r0_ready,
   output logic                r1_ready,
   input  logic [CMD_W-1:0]    r0_cmd,
   input  logic [CMD_W-1:0]    r1_cmd,
   output logic [NUM_LEDS-1:0] leds,
   output logic [NUM_LEDS-1:0] led_busy,
   output logic [NUM_LEDS-1:0] led_done
);

   localparam int PW = $clog2(TICK_DIV);

   logic [PW-1:0]       pre_q, pre_d;
   logic                tick;
   logic                last_q, last_d;
   logic                gnt1, acc;
   logic [CMD_W-1:0]    cmd_sel;
   logic [NUM_LEDS-1:0] cmd_we;

   always_comb begin
      tick  = (pre_q == PW'(TICK_DIV - 1));
      pre_d = tick ? '0 : pre_q + 1'b1;
   end

   // last_q = 1 means requester 1 was granted most recently; ties go to the other one.
   always_comb begin
      gnt1     = r1_valid && (!r0_valid || !last_q);
      acc      = rstn && (r0_valid || r1_valid);
      r0_ready = rstn && r0_valid && !gnt1;
      r1_ready = rstn && gnt1;
      last_d   = acc ? gnt1 : last_q;
      cmd_sel  = gnt1 ? r1_cmd : r0_cmd;
      for (int i = 0; i < NUM_LEDS; i++) begin
         cmd_we[i] = acc && (cmd_sel[CMD_IDX_LSB +: CMD_IDX_W] == CMD_IDX_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pre_q  <= '0;
         last_q <= 1'b1;
      end else begin
         pre_q  <= pre_d;
         last_q <= last_d;
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      led_channel u_ch (
         .clk      (clk),
         .rstn     (rstn),
         .tick     (tick),
         .cmd_we   (cmd_we[i]),
         .cmd_mode (cmd_sel[CMD_MODE_LSB +: CMD_MODE_W]),
         .cmd_cnt  (cmd_sel[CMD_CNT_LSB +: CMD_CNT_W]),
         .cmd_h    (cmd_sel[CMD_H_LSB +: CMD_H_W]),
         .led_n    (leds[i]),
         .busy     (led_busy[i]),
         .done     (led_done[i])
      );
   end

endmodule

// File: doc/led_pattern_sched.md
LED_PATTERN_SCHED -- requirements
Module: led_pattern_sched

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000, giving clk cycles per pattern tick (legal range 2..2^24).
REQ-002 The block SHALL have parameter NUM_LEDS, default 4, giving the number of LEDs driven (fixed at 4 in this revision).
REQ-003 The block SHALL have port clk, input, 1, the system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1, the reset: synchronous, active-low.
REQ-005 The block SHALL have ports r0_valid/r1_valid, input, 1 each, command valid from requester 0/1.
REQ-006 The block SHALL have ports r0_ready/r1_ready, output, 1 each, command accepted this cycle.
REQ-007 The block SHALL have ports r0_cmd/r1_cmd, input, 11 each, with fields [10:9] led index, [8:7] mode, [6:3] pulse count, [2:0] half-period exponent H.
REQ-008 The block SHALL have port leds, output, 4, the LED drive, active-low (0 = lit).
REQ-009 The block SHALL have port led_busy, output, 4, high while an LED runs BLINK or PULSE.
REQ-010 The block SHALL have port led_done, output, 4, a one-cycle pulse when a PULSE sequence completes.

Function
REQ-011 The prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert an internal tick for one cycle when the count equals TICK_DIV-1.
REQ-012 Handshake: a command SHALL be accepted only in a cycle where valid and ready are both high; ready SHALL be combinational from valid and the arbiter state.
REQ-013 The arbiter SHALL accept at most one command per cycle; ready SHALL not be asserted to a requester whose valid is low.
REQ-014 Arbitration rules:
- Only one requester valid: that requester SHALL be granted.
- Both valid: the requester not granted most recently SHALL win.
- The last-grant pointer SHALL update only on acceptance and SHALL reset to "requester 1" so that requester 0 wins the first tie.
REQ-015 An accepted command SHALL take effect on leds/led_busy on the clock edge after acceptance (1-cycle latency).
REQ-016 Mode 00 OFF SHALL drive the LED high (off) with busy=0.
REQ-017 Mode 01 ON SHALL drive the LED low (lit) with busy=0.
REQ-018 Mode 10 BLINK SHALL start lit and toggle after every 2^H ticks, indefinitely, with busy=1.
REQ-019 Mode 11 PULSE SHALL produce N pulses (N = count, with count 0 meaning 16), each lit for 2^H ticks then off for 2^H ticks, with busy=1.
REQ-020 PULSE completion: after the final off phase the channel SHALL go to OFF, drop busy, and pulse led_done for exactly one cycle.
REQ-021 Phase timing: each phase SHALL last exactly 2^H tick pulses counted after the phase begins; H=7 gives 128 ticks, and the 8-bit phase counter SHALL never overflow.
REQ-022 A command to any LED, busy or not, SHALL preempt that LED's current pattern immediately; an aborted PULSE SHALL NOT assert led_done.
REQ-023 If acceptance coincides with a phase end or with completion on the same LED, the new command SHALL win and led_done SHALL stay low.
REQ-024 Each LED channel SHALL be independent; a command to one LED SHALL not disturb any other LED's phase or counters.
REQ-025 Per-channel FSM states SHALL be OFF, ON, BLINK_ON, BLINK_OFF, PULSE_ON and PULSE_OFF, with transitions only on accepted commands or on phase completion as defined in REQ-016..REQ-023.

Reset
REQ-026 While rstn is low at a clock edge, the block SHALL force leds=4'b1111, led_busy=0, led_done=0, ready outputs low, prescaler=0, all channels OFF, and the pointer to requester 1.
REQ-027 Reset asserted mid-pattern SHALL abort the pattern without a led_done pulse; commands presented during reset SHALL be ignored.

Structure
REQ-028 Package led_sched_pkg SHALL hold the mode encodings (OFF/ON/BLINK/PULSE), the cmd field offsets and widths, the FSM state type, and NUM_LEDS.
REQ-029 Per-LED behaviour SHALL be implemented in sub-module led_channel, instantiated NUM_LEDS times; the top level SHALL hold the prescaler, the arbiter and the command decode.

Verification (bench uses TICK_DIV=4)
REQ-030 Scenario: after reset, r0 sends LED2 ON -> leds=4'b1011 one cycle after acceptance, and led_busy=0.
REQ-031 Scenario: r1 sends LED0 PULSE with count=2, H=1 -> LED0 is lit 2 ticks (8 cycles), off 8, lit 8, off 8; then led_done[0] pulses once and busy falls.
REQ-032 Scenario: r0 and r1 hold valid for 4 cycles -> grants alternate r0, r1, r0, r1, with only one ready per cycle.
REQ-033 Scenario: LED3 BLINK H=0, then an OFF command to LED3 issued mid-phase -> LED3 goes off on the next edge, busy=0, and no led_done.
REQ-034 Scenario: PULSE count=0, H=0 -> exactly 16 lit phases, then led_done.
REQ-035 Scenario: rstn low for 1 cycle during a PULSE -> leds=4'b1111, busy=0, and no led_done.
